// File: rtl/caliptra_ss_axi_wr_txn_capture.sv
// rtl/caliptra_ss_axi_wr_txn_capture.sv - passive AXI4 write-channel monitor that emits one record per completed write
module caliptra_ss_axi_wr_txn_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         nonempty,
    output logic         dropped
);
    localparam int PW = $clog2(D);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign nonempty = (count != '0);
    assign do_pop   = pop && nonempty;
    // a full queue still accepts a push when it is popped in the same cycle
    assign do_push  = push && ((count != (PW+1)'(D)) || do_pop);
    assign dropped  = push && !do_push;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module caliptra_ss_axi_wr_txn_capture #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 8,
    parameter int Q_DEPTH   = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              aw_valid,
    input  logic              aw_ready,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [7:0]        aw_len,
    input  logic              w_valid,
    input  logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_last,
    input  logic              b_valid,
    input  logic              b_ready,
    input  logic [ID_W-1:0]   b_id,
    input  logic [1:0]        b_resp,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [ID_W-1:0]   rec_id,
    output logic [7:0]        rec_len,
    output logic [8:0]        rec_beats,
    output logic [DATA_W-1:0] rec_csum,
    output logic [1:0]        rec_resp,
    output logic [2:0]        rec_err,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);
    localparam int AQW = ADDR_W + ID_W + 8;
    localparam int WQW = 9 + DATA_W;
    localparam int BQW = AQW + WQW + 1;
    localparam int RW  = AQW + WQW + 2 + 3;

    logic aw_hs, w_hs, wl, b_hs;
    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign wl    = w_hs && w_last;
    assign b_hs  = b_valid && b_ready;

    logic [8:0]        beat_cnt;
    logic [DATA_W-1:0] csum;
    logic [8:0]        closed_beats;
    logic [DATA_W-1:0] closed_csum;
    assign closed_beats = beat_cnt + 9'd1;
    assign closed_csum  = csum ^ w_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            csum     <= '0;
        end else if (w_hs) begin
            if (w_last) begin
                beat_cnt <= '0;
                csum     <= '0;
            end else begin
                beat_cnt <= closed_beats;
                csum     <= closed_csum;
            end
        end
    end

    logic           aw_push, aw_pop, aw_ne, aw_drop;
    logic [AQW-1:0] aw_head;
    logic           wd_push, wd_pop, wd_ne, wd_drop;
    logic [WQW-1:0] wd_head;
    logic           bp_ne, bp_drop;
    logic [BQW-1:0] bp_head, bp_push_data;
    logic           out_ne, out_drop;
    logic [RW-1:0]  out_head, rec_push_data, rec_word;

    // The oldest waiting item on each side wins; a same-cycle arrival only bypasses an empty queue.
    logic           pair;
    logic [AQW-1:0] pair_aw;
    logic [WQW-1:0] pair_w;
    logic           len_mis;
    assign pair    = (aw_ne || aw_hs) && (wd_ne || wl);
    assign pair_aw = aw_ne ? aw_head : {aw_addr, aw_id, aw_len};
    assign pair_w  = wd_ne ? wd_head : {closed_beats, closed_csum};
    assign len_mis = (pair_w[WQW-1 -: 9] != ({1'b0, pair_aw[7:0]} + 9'd1));

    assign aw_push = aw_hs && !(pair && !aw_ne);
    assign aw_pop  = pair && aw_ne;
    assign wd_push = wl && !(pair && !wd_ne);
    assign wd_pop  = pair && wd_ne;
    assign bp_push_data = {pair_aw, pair_w, len_mis};

    caliptra_ss_axi_wr_txn_fifo #(.W(AQW), .D(Q_DEPTH)) u_aw_q (
        .clk(clk), .rst_n(rst_n), .push(aw_push), .push_data({aw_addr, aw_id, aw_len}),
        .pop(aw_pop), .head(aw_head), .nonempty(aw_ne), .dropped(aw_drop)
    );

    caliptra_ss_axi_wr_txn_fifo #(.W(WQW), .D(Q_DEPTH)) u_wd_q (
        .clk(clk), .rst_n(rst_n), .push(wd_push), .push_data({closed_beats, closed_csum}),
        .pop(wd_pop), .head(wd_head), .nonempty(wd_ne), .dropped(wd_drop)
    );

    caliptra_ss_axi_wr_txn_fifo #(.W(BQW), .D(Q_DEPTH)) u_bp_q (
        .clk(clk), .rst_n(rst_n), .push(pair), .push_data(bp_push_data),
        .pop(b_hs), .head(bp_head), .nonempty(bp_ne), .dropped(bp_drop)
    );

    logic [AQW-1:0]  bh_aw;
    logic [WQW-1:0]  bh_w;
    logic [ID_W-1:0] bh_id;
    assign bh_aw = bp_head[BQW-1 -: AQW];
    assign bh_w  = bp_head[WQW:1];
    assign bh_id = bh_aw[ID_W+7:8];

    assign rec_push_data = bp_ne
        ? {bh_aw, bh_w, b_resp, 1'b0, (b_id != bh_id), bp_head[0]}
        : {{ADDR_W{1'b0}}, b_id, 8'd0, {WQW{1'b0}}, b_resp, 3'b100};

    caliptra_ss_axi_wr_txn_fifo #(.W(RW), .D(OUT_DEPTH)) u_out_q (
        .clk(clk), .rst_n(rst_n), .push(b_hs), .push_data(rec_push_data),
        .pop(rec_valid && rec_ready), .head(out_head), .nonempty(out_ne), .dropped(out_drop)
    );

    assign rec_valid = out_ne;
    assign rec_word  = out_ne ? out_head : '0;
    assign {rec_addr, rec_id, rec_len, rec_beats, rec_csum, rec_resp, rec_err} = rec_word;

    logic [2:0]  n_drop;
    logic [16:0] drop_sum;
    assign n_drop   = 3'(aw_drop) + 3'(wd_drop) + 3'(bp_drop) + 3'(out_drop);
    assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (n_drop != 3'd0) begin
            overflow <= 1'b1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
endmodule

// File: doc/caliptra_ss_axi_wr_txn_capture.md
Name: caliptra_ss_axi_wr_txn_capture

Overview:
- Passive AXI4 write-channel monitor. Sits directly downstream of the AXI VIP manager that drives the Caliptra SS subsystem fabric in the integration testbench.
- Snoops AW/W/B handshakes and assembles each completed write into one record: address, ID, length, beat count, data checksum, response, error flags.
- Records are queued in a FIFO that the scoreboard drains with valid/ready.
- Never drives or back-pressures the monitored bus.

Parameters:
- ADDR_W, 32, AW address width
- DATA_W, 64, W data width; also the checksum width
- ID_W, 8, AXI ID width
- Q_DEPTH, 4, depth of the internal AW queue, W-done queue and B-pending queue (power of 2, ≥2)
- OUT_DEPTH, 8, record FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- aw_valid, aw_ready  in  1 each  monitored AW handshake
- aw_addr  in  ADDR_W  AW address
- aw_id  in  ID_W  AW ID
- aw_len  in  8  AXI AWLEN
- w_valid, w_ready  in  1 each  monitored W handshake
- w_data  in  DATA_W  W data
- w_last  in  1  WLAST
- b_valid, b_ready  in  1 each  monitored B handshake
- b_id  in  ID_W  B ID
- b_resp  in  2  BRESP
- rec_valid  out  1  record available
- rec_ready  in  1  scoreboard accepts record
- rec_addr  out  ADDR_W  record address
- rec_id  out  ID_W  record ID
- rec_len  out  8  record AWLEN
- rec_beats  out  9  W beats counted
- rec_csum  out  DATA_W  XOR of all beats
- rec_resp  out  2  BRESP
- rec_err  out  3  {orphan_b, id_mismatch, len_mismatch}
- overflow  out  1  sticky: any queue or FIFO push was dropped
- drop_cnt  out  16  count of dropped items, saturating

Behaviour:
- Reset (async assert, sync deassert use): all queues empty; staging beat counter 0; staging checksum 0. All outputs 0: rec_valid=0, rec_* fields 0, overflow=0, drop_cnt=0. Reset mid-transaction discards all partial state; no record is emitted for it.
- Handshake definition: a channel handshake is valid&&ready sampled at a rising edge. Nothing else is observed.
- AW handshake: pushes {addr, id, len} into the AW queue.
- W handshake: beat counter +1; checksum ^= w_data.
- W handshake with w_last=1: closes staging as {beats incl. this one, csum incl. this beat}. Counter and checksum then reset to 0, or restart from the new beat if a beat is accepted the next cycle.
- Pairing at WLAST cycle t: if an AW is available, the pair is formed in cycle t and pushed to the B-pending queue. "Available" means the AW queue head, or an AW handshaking in the same cycle t when the AW queue is empty.
  - Else: the closed W goes into the W-done queue.
  - Whenever the AW queue and W-done queue heads both exist, they pair in that cycle, one pair per cycle.
  - A pair pushed at cycle t is visible to B matching from t+1.
- Pair contents: len_mismatch = (beats != aw_len+1).
- B handshake pops the B-pending head:
  - id_mismatch = (b_id != head id).
  - If the B-pending queue is empty: orphan_b=1, and addr/id/len/beats/csum are taken as 0 with rec_id=b_id.
  - The record is pushed into the output FIFO at that edge, so rec_valid rises on the next cycle when the FIFO was empty.
- Completion order: B is matched strictly in completion order. Out-of-order B across IDs is reported as id_mismatch. This is intentional: the VIP is configured for in-order responses.
- Output FIFO: standard FWFT. Pop on rec_valid&&rec_ready. Push and pop in the same cycle on a full FIFO is allowed and nothing is dropped.
- Drops: a push into any full queue or FIFO is discarded, overflow is set to 1, and drop_cnt +1 (saturates at 0xFFFF). overflow clears only on reset.
- Simultaneous events: AW, W-last, pairing, B and output pop may all occur in one cycle. Each queue supports one push and one pop per cycle. Queue counts must stay exact.

Test Plan:
- Single write addr=0x1000_0040, id=0x3, len=3, data 0x1,0x2,0x4,0x8, BRESP=OKAY. Expect one record with beats=4, csum=0xF, rec_err=0, rec_valid 1 cycle after B.
- W beats (len=1) fully sent before AW. Expect pairing on the AW cycle and a correct record with beats=2; no error.
- AW len=2 with WLAST on beat 2. Expect beats=2, len_mismatch=1.
- Two writes id 0x1 then 0x2, B returns 0x2 first. Expect the first record with id=0x1 and id_mismatch=1.
- B with no prior write. Expect rec_err=3'b100 and rec_id=b_id.
- rec_ready=0 while OUT_DEPTH+1 writes complete. Expect 8 records, overflow=1, drop_cnt=1, records intact in order after rec_ready=1.
- Assert rst_n low mid-burst. Expect all outputs 0; next clean write yields a correct record.
